// File: rtl/kronos_ex_alu_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kronos_ex_alu_stage : execute stage (ALU + output register + fwd tap)       |
// | Optional skid entry enabled by defining KRONOS_EX_SKID_EN                   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+

module kronos_alu (
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    input  logic [3:0]  i_aluop,
    output logic [31:0] o_result
);
    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b1000;
    localparam logic [3:0] c_ALU_SLL  = 4'b0001;
    localparam logic [3:0] c_ALU_SLT  = 4'b0010;
    localparam logic [3:0] c_ALU_SLTU = 4'b0011;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SRL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRA  = 4'b1101;
    localparam logic [3:0] c_ALU_OR   = 4'b0110;
    localparam logic [3:0] c_ALU_AND  = 4'b0111;

    logic [4:0] w_shamt;
    assign w_shamt = i_op2[4:0];

    always_comb begin
        o_result = '0;
        case (i_aluop)
            c_ALU_ADD:  o_result = i_op1 + i_op2;
            c_ALU_SUB:  o_result = i_op1 - i_op2;
            c_ALU_SLL:  o_result = i_op1 << w_shamt;
            c_ALU_SLT:  o_result = {31'b0, $signed(i_op1) < $signed(i_op2)};
            c_ALU_SLTU: o_result = {31'b0, i_op1 < i_op2};
            c_ALU_XOR:  o_result = i_op1 ^ i_op2;
            c_ALU_SRL:  o_result = i_op1 >> w_shamt;
            c_ALU_SRA:  o_result = 32'($signed(i_op1) >>> w_shamt);
            c_ALU_OR:   o_result = i_op1 | i_op2;
            c_ALU_AND:  o_result = i_op1 & i_op2;
            default:    o_result = '0;
        endcase
    end
endmodule

module kronos_ex_alu_stage #(
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [31:0]     decode_op1,
    input  logic [31:0]     decode_op2,
    input  logic [3:0]      decode_aluop,
    input  logic [RD_W-1:0] decode_rd,
    input  logic            decode_regwr,
    input  logic            decode_vld,
    output logic            decode_rdy,
    output logic [31:0]     execute_result,
    output logic [RD_W-1:0] execute_rd,
    output logic            execute_regwr,
    output logic            execute_vld,
    input  logic            execute_rdy,
    output logic            fwd_vld,
    output logic [RD_W-1:0] fwd_rd,
    output logic [31:0]     fwd_data
);
    logic [31:0]     w_alu_result;
    logic            w_out_fire;
    logic            w_out_free;
    logic            w_in_fire;

    logic [31:0]     r_out_result;
    logic [RD_W-1:0] r_out_rd;
    logic            r_out_regwr;
    logic            r_out_vld;

    kronos_alu u_alu (
        .i_op1    (decode_op1),
        .i_op2    (decode_op2),
        .i_aluop  (decode_aluop),
        .o_result (w_alu_result)
    );

    assign w_out_fire = r_out_vld & execute_rdy;
    assign w_out_free = ~r_out_vld | execute_rdy;

`ifdef KRONOS_EX_SKID_EN
    logic [31:0]     r_skid_result;
    logic [RD_W-1:0] r_skid_rd;
    logic            r_skid_regwr;
    logic            r_skid_vld;

    // Ready comes straight from a flop, so WB backpressure never reaches ID combinationally.
    assign decode_rdy = ~r_skid_vld;
    assign w_in_fire  = decode_vld & ~r_skid_vld & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_result  <= '0;
            r_out_rd      <= '0;
            r_out_regwr   <= 1'b0;
            r_out_vld     <= 1'b0;
            r_skid_result <= '0;
            r_skid_rd     <= '0;
            r_skid_regwr  <= 1'b0;
            r_skid_vld    <= 1'b0;
        end else if (flush) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (r_skid_vld) begin
            // A full skid implies a valid output, so execute_rdy alone means a transfer out.
            if (execute_rdy) begin
                r_out_result <= r_skid_result;
                r_out_rd     <= r_skid_rd;
                r_out_regwr  <= r_skid_regwr;
                r_skid_vld   <= 1'b0;
            end
        end else if (w_in_fire) begin
            if (w_out_free) begin
                r_out_result <= w_alu_result;
                r_out_rd     <= decode_rd;
                r_out_regwr  <= decode_regwr;
                r_out_vld    <= 1'b1;
            end else begin
                r_skid_result <= w_alu_result;
                r_skid_rd     <= decode_rd;
                r_skid_regwr  <= decode_regwr;
                r_skid_vld    <= 1'b1;
            end
        end else if (w_out_fire) begin
            r_out_vld <= 1'b0;
        end
    end
`else
    assign decode_rdy = w_out_free;
    assign w_in_fire  = decode_vld & w_out_free & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_result <= '0;
            r_out_rd     <= '0;
            r_out_regwr  <= 1'b0;
            r_out_vld    <= 1'b0;
        end else if (flush) begin
            r_out_vld <= 1'b0;
        end else if (w_in_fire) begin
            r_out_result <= w_alu_result;
            r_out_rd     <= decode_rd;
            r_out_regwr  <= decode_regwr;
            r_out_vld    <= 1'b1;
        end else if (w_out_fire) begin
            r_out_vld <= 1'b0;
        end
    end
`endif

    assign execute_result = r_out_result;
    assign execute_rd     = r_out_rd;
    assign execute_regwr  = r_out_regwr;
    assign execute_vld    = r_out_vld;

    // x0 is hardwired zero, so it is never a forwarding source.
    assign fwd_vld  = r_out_vld & r_out_regwr & (r_out_rd != '0);
    assign fwd_rd   = r_out_rd;
    assign fwd_data = r_out_result;
endmodule

`default_nettype wire

// File: tb/tb_kronos_ex_alu_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_kronos_ex_alu_stage : directed + randomized bench with queue model       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_kronos_ex_alu_stage;
    localparam int RD_W = 5;
`ifdef KRONOS_EX_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic [31:0]     decode_op1 = '0;
    logic [31:0]     decode_op2 = '0;
    logic [3:0]      decode_aluop = '0;
    logic [RD_W-1:0] decode_rd = '0;
    logic            decode_regwr = 1'b0;
    logic            decode_vld = 1'b0;
    logic            decode_rdy;
    logic [31:0]     execute_result;
    logic [RD_W-1:0] execute_rd;
    logic            execute_regwr;
    logic            execute_vld;
    logic            execute_rdy = 1'b0;
    logic            fwd_vld;
    logic [RD_W-1:0] fwd_rd;
    logic [31:0]     fwd_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0]     res;
        logic [RD_W-1:0] rd;
        logic            regwr;
    } item_t;

    item_t q[$];

    kronos_ex_alu_stage #(.RD_W(RD_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .decode_op1(decode_op1), .decode_op2(decode_op2), .decode_aluop(decode_aluop),
        .decode_rd(decode_rd), .decode_regwr(decode_regwr),
        .decode_vld(decode_vld), .decode_rdy(decode_rdy),
        .execute_result(execute_result), .execute_rd(execute_rd),
        .execute_regwr(execute_regwr), .execute_vld(execute_vld), .execute_rdy(execute_rdy),
        .fwd_vld(fwd_vld), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int unsigned sh;
        sh = int'(b[4:0]);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << sh;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_XOR:  return a ^ b;
            OP_SRL:  return a >> sh;
            OP_SRA:  return 32'($signed(a) >>> sh);
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // Stage modelled as a FIFO of capacity CAP.
    function automatic bit model_rdy();
`ifdef KRONOS_EX_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || execute_rdy;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst || flush) begin
            q.delete();
        end else if (decode_vld && model_rdy()) begin
            if (q.size() > 0 && execute_rdy) void'(q.pop_front());
            q.push_back('{res: ref_alu(decode_aluop, decode_op1, decode_op2),
                          rd: decode_rd, regwr: decode_regwr});
        end else if (q.size() > 0 && execute_rdy) begin
            void'(q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                         logic [RD_W-1:0] rd, logic wr, logic vld);
        decode_aluop = op;
        decode_op1   = a;
        decode_op2   = b;
        decode_rd    = rd;
        decode_regwr = wr;
        decode_vld   = vld;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (execute_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", execute_vld); end
        n_tests++;
        if (execute_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", execute_result); end
        n_tests++;
        if (execute_rd !== '0 || execute_regwr !== 1'b0) begin
            n_fail++; $display("FAIL reset_rd_regwr: got %0d/%b expected 0/0", execute_rd, execute_regwr);
        end
        n_tests++;
        if (decode_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_decode_rdy: got %b expected 1", decode_rdy); end
        n_tests++;
        if (fwd_vld !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_vld: got %b expected 0", fwd_vld); end
    endtask

    task automatic test_add();
        execute_rdy = 1'b1;
        drive(OP_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b1);
        tick();
        decode_vld = 1'b0;
        n_tests++;
        if (execute_vld !== 1'b1 || execute_result !== 32'h0000000C) begin
            n_fail++; $display("FAIL add: got vld=%b res=%h expected vld=1 res=0000000c", execute_vld, execute_result);
        end
        n_tests++;
        if (fwd_vld !== 1'b1 || fwd_rd !== 5'd3 || fwd_data !== 32'h0000000C) begin
            n_fail++; $display("FAIL add_fwd: got %b/%0d/%h expected 1/3/0000000c", fwd_vld, fwd_rd, fwd_data);
        end
        tick();
        n_tests++;
        if (execute_vld !== 1'b0) begin n_fail++; $display("FAIL add_drain: got vld=%b expected 0", execute_vld); end
    endtask

    task automatic test_back_to_back();
        execute_rdy = 1'b1;
        drive(OP_SUB, 32'd3, 32'd5, 5'd1, 1'b1, 1'b1);
        tick();
        n_tests++;
        if (execute_vld !== 1'b1 || execute_result !== 32'hFFFFFFFE) begin
            n_fail++; $display("FAIL b2b_sub: got %b/%h expected 1/fffffffe", execute_vld, execute_result);
        end
        drive(OP_SRA, 32'h80000000, 32'd4, 5'd2, 1'b1, 1'b1);
        tick();
        n_tests++;
        if (execute_vld !== 1'b1 || execute_result !== 32'hF8000000) begin
            n_fail++; $display("FAIL b2b_sra: got %b/%h expected 1/f8000000", execute_vld, execute_result);
        end
        drive(OP_SLTU, 32'd1, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b1);
        tick();
        n_tests++;
        if (execute_vld !== 1'b1 || execute_result !== 32'h00000001 || execute_rd !== 5'd4) begin
            n_fail++; $display("FAIL b2b_sltu: got %b/%h/%0d expected 1/00000001/4", execute_vld, execute_result, execute_rd);
        end
        decode_vld = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        item_t exp_q[$];
        item_t cur;
        logic [31:0] a, b;
        int cnt = 0;
        int got = 0;
        execute_rdy = 1'b0;
        a = $urandom; b = $urandom;
        drive(OP_XOR, a, b, 5'd9, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (i > 0) begin
                n_tests++;
                if (execute_vld !== 1'b1 || execute_result !== exp_q[0].res) begin
                    n_fail++; $display("FAIL stall_stable: got %b/%h expected 1/%h", execute_vld, execute_result, exp_q[0].res);
                end
            end
            if (decode_rdy === 1'b1) begin
                cur = '{res: ref_alu(decode_aluop, decode_op1, decode_op2), rd: decode_rd, regwr: 1'b1};
                exp_q.push_back(cur);
                cnt++;
                tick();
                a = $urandom; b = $urandom;
                drive(OP_ADD, a, b, 5'(10 + cnt), 1'b1, 1'b1);
            end else begin
                tick();
            end
        end
        #1;
        n_tests++;
        if (cnt != CAP) begin n_fail++; $display("FAIL stall_accepted: got %0d expected %0d", cnt, CAP); end
        n_tests++;
        if (decode_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_rdy: got %b expected 0", decode_rdy); end
        decode_vld  = 1'b0;
        execute_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (execute_vld === 1'b1) begin
                got++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stall_dup: got extra res=%h expected none", execute_result);
                end else begin
                    if (execute_result !== exp_q[0].res || execute_rd !== exp_q[0].rd) begin
                        n_fail++; $display("FAIL stall_order: got %h/%0d expected %h/%0d",
                                           execute_result, execute_rd, exp_q[0].res, exp_q[0].rd);
                    end
                    void'(exp_q.pop_front());
                end
            end
            tick();
        end
        n_tests++;
        if (got != CAP) begin n_fail++; $display("FAIL stall_drain_count: got %0d expected %0d", got, CAP); end
    endtask

    task automatic test_flush();
        execute_rdy = 1'b0;
        for (int i = 0; i < CAP; i++) begin
            drive(OP_ADD, 32'(100 + i), 32'd1, 5'(20 + i), 1'b1, 1'b1);
            tick();
        end
        drive(OP_OR, 32'hDEAD0000, 32'h0000BEEF, 5'd30, 1'b1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        decode_vld = 1'b0;
        #1;
        n_tests++;
        if (execute_vld !== 1'b0) begin n_fail++; $display("FAIL flush_vld: got %b expected 0", execute_vld); end
        n_tests++;
        if (decode_rdy !== 1'b1) begin n_fail++; $display("FAIL flush_rdy: got %b expected 1", decode_rdy); end
        execute_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (execute_vld !== 1'b0) begin
                n_fail++; $display("FAIL flush_leak: got vld=1 res=%h expected vld=0", execute_result);
            end
        end
    endtask

    task automatic test_reset_mid();
        execute_rdy = 1'b0;
        for (int i = 0; i < CAP; i++) begin
            drive(OP_SUB, 32'(50 + i), 32'd3, 5'(5 + i), 1'b1, 1'b1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        decode_vld = 1'b0;
        #1;
        n_tests++;
        if (execute_vld !== 1'b0 || execute_result !== 32'h0 || execute_rd !== '0 || execute_regwr !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs: got %b/%h/%0d/%b expected 0/00000000/0/0",
                               execute_vld, execute_result, execute_rd, execute_regwr);
        end
        n_tests++;
        if (decode_rdy !== 1'b1 || fwd_vld !== 1'b0) begin
            n_fail++; $display("FAIL midrst_rdy_fwd: got %b/%b expected 1/0", decode_rdy, fwd_vld);
        end
        execute_rdy = 1'b1;
        drive(OP_OR, 32'h000000F0, 32'h0000000F, 5'd7, 1'b1, 1'b1);
        tick();
        decode_vld = 1'b0;
        n_tests++;
        if (execute_vld !== 1'b1 || execute_result !== 32'h000000FF) begin
            n_fail++; $display("FAIL midrst_or: got %b/%h expected 1/000000ff", execute_vld, execute_result);
        end
        tick();
    endtask

    task automatic test_rd0();
        execute_rdy = 1'b1;
        drive(OP_ADD, 32'd1, 32'd1, 5'd0, 1'b1, 1'b1);
        tick();
        decode_vld = 1'b0;
        n_tests++;
        if (execute_vld !== 1'b1 || execute_result !== 32'd2) begin
            n_fail++; $display("FAIL rd0_result: got %b/%h expected 1/00000002", execute_vld, execute_result);
        end
        n_tests++;
        if (fwd_vld !== 1'b0) begin n_fail++; $display("FAIL rd0_fwd: got %b expected 0", fwd_vld); end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] ops [10];
        item_t h;
        bit exp_fwd;
        ops = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND};
        for (int c = 0; c < 400; c++) begin
            drive(ops[$urandom_range(0, 9)],
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 7));
            execute_rdy = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 39) == 0);
            #1;
            n_tests++;
            if (decode_rdy !== model_rdy()) begin
                n_fail++; $display("FAIL rand_rdy@%0d: got %b expected %b", c, decode_rdy, model_rdy());
            end
            n_tests++;
            if (execute_vld !== (q.size() > 0)) begin
                n_fail++; $display("FAIL rand_vld@%0d: got %b expected %b", c, execute_vld, q.size() > 0);
            end else if (q.size() > 0) begin
                h = q[0];
                exp_fwd = h.regwr && (h.rd != 0);
                n_tests++;
                if (execute_result !== h.res || execute_rd !== h.rd || execute_regwr !== h.regwr) begin
                    n_fail++; $display("FAIL rand_payload@%0d: got %h/%0d/%b expected %h/%0d/%b",
                                       c, execute_result, execute_rd, execute_regwr, h.res, h.rd, h.regwr);
                end
                n_tests++;
                if (fwd_vld !== exp_fwd || fwd_data !== h.res || fwd_rd !== h.rd) begin
                    n_fail++; $display("FAIL rand_fwd@%0d: got %b/%0d/%h expected %b/%0d/%h",
                                       c, fwd_vld, fwd_rd, fwd_data, exp_fwd, h.rd, h.res);
                end
            end
            tick();
        end
        flush = 1'b0;
        decode_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        test_rd0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
